// File: rtl/imem_loadable.sv
// Loadable instruction memory: hardware clear after reset, runtime program load, registered fetch.
// Fetch latency 1 cycle; stall holds the fetch output; out-of-range accesses raise addr_fault.
module imem_loadable #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_done,
  input  logic              reload,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              addr_fault,
  output logic              ready,
  output logic              clearing
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              load_in_range;
  logic              fetch_in_range;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Range checks use the full address width so large addresses never alias into the array.
  assign load_in_range  = {1'b0, load_addr} < DEPTH_EXT;
  assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_EXT;

  assign ready    = (state == S_RUN);
  assign clearing = (state == S_CLEAR);

  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (clr_cnt == LAST_IDX) state_next = S_LOAD;
      S_LOAD:  if (load_done) state_next = S_RUN;
      S_RUN:   if (reload) state_next = S_LOAD;
      default: state_next = S_CLEAR;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = NOP_WORD;
    if (state == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt[IDX_W-1:0];
    end else if (state == S_LOAD && load_we && load_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = load_addr[IDX_W-1:0];
      mem_wdata = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CLEAR;
      clr_cnt     <= '0;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_CLEAR: begin
          clr_cnt     <= clr_cnt + 1'b1;
          instr_valid <= 1'b0;
          addr_fault  <= 1'b0;
        end
        S_LOAD: begin
          instr_valid <= 1'b0;
          addr_fault  <= load_we && !load_in_range;
        end
        S_RUN: begin
          // reload wins over stall, stall wins over a new fetch
          if (reload) begin
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
          end else if (!stall) begin
            if (fetch_req) begin
              instr_valid <= 1'b1;
              if (fetch_in_range) begin
                instr      <= mem[fetch_addr[IDX_W-1:0]];
                addr_fault <= 1'b0;
              end else begin
                instr      <= NOP_WORD;
                addr_fault <= 1'b1;
              end
            end else begin
              instr_valid <= 1'b0;
              addr_fault  <= 1'b0;
            end
          end
        end
        default: begin
          instr_valid <= 1'b0;
          addr_fault  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable with DEPTH=16: clear, load, fetch, faults, stall, reload, reset.
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_we;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        reload;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic        addr_fault;
  logic        ready;
  logic        clearing;

  int checks = 0;
  int passed = 0;

  imem_loadable #(
    .DATA_W(32), .ADDR_W(16), .DEPTH(16), .NOP_WORD(32'h0000_0000)
  ) dut (
    .clk(clk), .rst(rst),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
    .reload(reload), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .addr_fault(addr_fault),
    .ready(ready), .clearing(clearing)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [15:0] a, input logic [31:0] d, input logic done);
    load_we = 1'b1; load_addr = a; load_data = d; load_done = done;
    tick();
    load_we = 1'b0; load_done = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic count_clear(input string name);
    int n = 0;
    while (clearing === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16) $display("FAIL %s: clearing cycles got %0d expected 16", name, n);
    else passed++;
    checks++;
    if (ready !== 1'b0 || clearing !== 1'b0)
      $display("FAIL %s_to_load: ready=%b clearing=%b expected 0 0", name, ready, clearing);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (clearing !== 1'b1 || ready !== 1'b0 || instr !== 32'h0 || instr_valid !== 1'b0 || addr_fault !== 1'b0)
      $display("FAIL reset_state: clr=%b rdy=%b instr=%h vld=%b flt=%b expected 1 0 00000000 0 0",
               clearing, ready, instr, instr_valid, addr_fault);
    else passed++;
    count_clear("reset_clear");
  endtask

  task automatic test_clear_empty();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    checks++;
    if (ready !== 1'b1) $display("FAIL run_entry: ready got %b expected 1", ready);
    else passed++;
    fetch(16'd5);
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b1 || addr_fault !== 1'b0)
      $display("FAIL empty_fetch: instr=%h vld=%b flt=%b expected 00000000 1 0", instr, instr_valid, addr_fault);
    else passed++;
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic test_load_fetch();
    load_word(16'd0, 32'h8028_0032, 1'b0);
    load_word(16'd1, 32'h8570_0000, 1'b0);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    fetch_req = 1'b1; fetch_addr = 16'd0;
    tick();
    checks++;
    if (instr !== 32'h8028_0032 || instr_valid !== 1'b1)
      $display("FAIL b2b_fetch0: instr=%h vld=%b expected 80280032 1", instr, instr_valid);
    else passed++;
    fetch_addr = 16'd1;
    tick();
    fetch_req = 1'b0;
    checks++;
    if (instr !== 32'h8570_0000 || instr_valid !== 1'b1)
      $display("FAIL b2b_fetch1: instr=%h vld=%b expected 85700000 1", instr, instr_valid);
    else passed++;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h8570_0000)
      $display("FAIL idle_after_fetch: instr=%h vld=%b expected 85700000 0", instr, instr_valid);
    else passed++;
  endtask

  task automatic test_out_of_range();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    load_word(16'd16, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (addr_fault !== 1'b1) $display("FAIL load_fault_pulse: got %b expected 1", addr_fault);
    else passed++;
    tick();
    checks++;
    if (addr_fault !== 1'b0) $display("FAIL load_fault_clear: got %b expected 0", addr_fault);
    else passed++;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    fetch(16'd0);
    checks++;
    if (instr !== 32'h8028_0032 || addr_fault !== 1'b0)
      $display("FAIL no_alias_fetch0: instr=%h flt=%b expected 80280032 0", instr, addr_fault);
    else passed++;
    fetch(16'd26);
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b1 || addr_fault !== 1'b1)
      $display("FAIL fetch_oor26: instr=%h vld=%b flt=%b expected 00000000 1 1", instr, instr_valid, addr_fault);
    else passed++;
    fetch(16'd15);
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b1 || addr_fault !== 1'b0)
      $display("FAIL fetch_last: instr=%h vld=%b flt=%b expected 00000000 1 0", instr, instr_valid, addr_fault);
    else passed++;
    fetch(16'd16);
    checks++;
    if (addr_fault !== 1'b1 || instr_valid !== 1'b1)
      $display("FAIL fetch_depth: vld=%b flt=%b expected 1 1", instr_valid, addr_fault);
    else passed++;
  endtask

  task automatic test_stall();
    fetch(16'd1);
    stall = 1'b1; fetch_req = 1'b1; fetch_addr = 16'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr !== 32'h8570_0000 || instr_valid !== 1'b1 || addr_fault !== 1'b0)
        $display("FAIL stall_hold%0d: instr=%h vld=%b flt=%b expected 85700000 1 0",
                 i, instr, instr_valid, addr_fault);
      else passed++;
    end
    stall = 1'b0; fetch_req = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h8570_0000)
      $display("FAIL stall_release: instr=%h vld=%b expected 85700000 0", instr, instr_valid);
    else passed++;
    fetch(16'd20);
    stall = 1'b1; fetch_req = 1'b1; fetch_addr = 16'd1;
    tick();
    stall = 1'b0; fetch_req = 1'b0;
    checks++;
    if (addr_fault !== 1'b1 || instr !== 32'h0 || instr_valid !== 1'b1)
      $display("FAIL stall_hold_fault: instr=%h vld=%b flt=%b expected 00000000 1 1", instr, instr_valid, addr_fault);
    else passed++;
  endtask

  task automatic test_reload();
    reload = 1'b1; fetch_req = 1'b1; fetch_addr = 16'd0;
    tick();
    reload = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || ready !== 1'b0 || addr_fault !== 1'b0)
      $display("FAIL reload_drop: vld=%b rdy=%b flt=%b expected 0 0 0", instr_valid, ready, addr_fault);
    else passed++;
    tick();
    fetch_req = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) $display("FAIL load_ignores_fetch: vld=%b expected 0", instr_valid);
    else passed++;
    load_word(16'd1, 32'h0028_0064, 1'b1);
    checks++;
    if (ready !== 1'b1) $display("FAIL load_done_with_we: ready=%b expected 1", ready);
    else passed++;
    fetch(16'd1);
    checks++;
    if (instr !== 32'h0028_0064) $display("FAIL reload_fetch1: instr=%h expected 00280064", instr);
    else passed++;
    fetch(16'd0);
    checks++;
    if (instr !== 32'h8028_0032) $display("FAIL reload_retain0: instr=%h expected 80280032", instr);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    load_word(16'd2, 32'hA9A8_0001, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_clear("midload_clear");
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    fetch(16'd2);
    checks++;
    if (instr !== 32'h0 || instr_valid !== 1'b1)
      $display("FAIL cleared_fetch2: instr=%h vld=%b expected 00000000 1", instr, instr_valid);
    else passed++;
    fetch(16'd0);
    checks++;
    if (instr !== 32'h0) $display("FAIL cleared_fetch0: instr=%h expected 00000000", instr);
    else passed++;
  endtask

  initial begin
    rst = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    reload = 1'b0; fetch_req = 1'b0; fetch_addr = '0; stall = 1'b0;
    test_reset();
    test_clear_empty();
    test_load_fetch();
    test_out_of_range();
    test_stall();
    test_reload();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory, successor to the single-cycle CPU's fixed combinational instruction ROM.
- Adds a registered fetch port with valid/stall handling and a program-load port, so programs are written at runtime instead of fixed at elaboration.
- Adds a hardware clear sequence after reset and an out-of-range address fault.
- Sits between the PC register and the decoder; the load port is driven by the testbench or a boot loader.

Parameters:
- DATA_W, 32, instruction word width in bits.
- ADDR_W, 16, fetch/load address width (word index, same as PC width).
- DEPTH, 1024, number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- NOP_WORD, 32'h0000_0000, fill value for clear and for faulted fetches.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- load_we  in  1  write strobe for the load port.
- load_addr  in  ADDR_W  word index for the load write.
- load_data  in  DATA_W  instruction word to write.
- load_done  in  1  ends the LOAD phase.
- reload  in  1  RUN -> LOAD request.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  PC word index.
- stall  in  1  holds the fetch output.
- instr  out  DATA_W  fetched instruction (registered).
- instr_valid  out  1  instr holds a new fetch result.
- addr_fault  out  1  out-of-range access flag.
- ready  out  1  block is in RUN.
- clearing  out  1  block is in CLEAR.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=CLEAR, clr_cnt=0, instr=NOP_WORD, instr_valid=0, addr_fault=0, ready=0, clearing=1.
- Reset while in any state restarts CLEAR. Memory contents are cleared by the CLEAR sequence, not by reset itself.
- States: CLEAR, LOAD, RUN.
- CLEAR:
  - Each cycle: M[clr_cnt] <= NOP_WORD, clr_cnt++.
  - In the cycle clr_cnt==DEPTH-1, the final word is written and next state is LOAD.
  - Duration is exactly DEPTH cycles. All inputs except rst are ignored.
- LOAD:
  - load_we=1 and load_addr<DEPTH: M[load_addr] <= load_data.
  - load_we=1 and load_addr>=DEPTH: write is dropped; addr_fault=1 for the next cycle only.
  - load_done=1: next state RUN. A load_we in the same cycle still completes.
  - fetch_req is ignored; instr_valid=0.
- RUN (ready=1):
  - Priority order: reload, then stall, then fetch_req.
  - reload=1: next state LOAD; instr_valid <= 0; addr_fault <= 0; any same-cycle fetch is dropped. Memory contents are kept.
  - stall=1: instr, instr_valid and addr_fault all hold their current values.
  - fetch_req=1, fetch_addr<DEPTH: instr <= M[fetch_addr], instr_valid <= 1, addr_fault <= 0.
  - fetch_req=1, fetch_addr>=DEPTH: instr <= NOP_WORD, instr_valid <= 1, addr_fault <= 1.
  - fetch_req=0: instr_valid <= 0, addr_fault <= 0, instr holds.
  - Fetch latency is 1 cycle. Back-to-back fetches sustain one word per cycle.
  - load_we and load_done are ignored in RUN.
- Address rules:
  - An address is in range iff addr < DEPTH, compared unsigned at full ADDR_W.
  - No wrap-around and no truncation of the address.
- Memory: single array of DEPTH x DATA_W. It has one write source per state (clear counter in CLEAR, load port in LOAD) and one synchronous read in RUN.

Test Plan (DEPTH=16, ADDR_W=16, NOP_WORD=0):
- Clear then empty read: hold rst 1 cycle. Expect clearing=1 for exactly 16 cycles, then LOAD. Assert load_done, then fetch_addr=5 -> next cycle instr=0, instr_valid=1, addr_fault=0.
- Load and fetch: in LOAD, write M[0]=32'h8028_0032 and M[1]=32'h8570_0000, then load_done. Fetch 0 then 1 back-to-back -> instr=32'h8028_0032 then 32'h8570_0000, instr_valid=1 on both cycles.
- Out of range:
  - LOAD write to addr 16 -> addr_fault pulses 1 cycle; a later fetch of addr 0 is unaffected.
  - RUN fetch of addr 26 -> instr=0, instr_valid=1, addr_fault=1.
- Stall: fetch addr 1 (value 32'h8570_0000), then stall=1 for 3 cycles with fetch_addr=0 -> instr, instr_valid and addr_fault held unchanged. Release stall with fetch_req=0 -> instr_valid=0.
- Reload: in RUN, assert reload together with fetch_req -> no valid output, ready=0 next cycle. Write M[1]=32'h0028_0064, load_done, fetch 1 -> 32'h0028_0064. M[0] is retained.
- Reset mid-LOAD: after writing M[2]=32'hA9A8_0001, assert rst -> 16-cycle CLEAR. Load_done, then fetch 2 -> instr=0.
